hpdcache_flush_walker: RTL and testbench

Flush-all sequencer placed directly upstream of the HPDcache flush controller. On a start request it walks every set of the cache directory. For each valid dirty line it issues one allocation to the flush controller and clears the line's dirty bit. It then waits until the flush controller has drained and signals completion. While busy, the cache controller holds off all other directory accesses, so the walker has exclusive ownership of the directory.

---
 rtl/hpdcache_flush_walker.sv | 153 +++++++++++++++
 tb/tb_hpdcache_flush_walker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_flush_walker.sv
// Flush-all sequencer: walks every directory set, hands each valid dirty line to the
// flush controller, clears its dirty bit, then waits for the flush controller to drain.
module hpdcache_flush_walker #(
    parameter int unsigned Sets     = 64,
    parameter int unsigned Ways     = 8,
    parameter int unsigned TagWidth = 20,
    parameter int unsigned SetWidth = $clog2(Sets)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         start_i,
    output logic                         start_ready_o,
    output logic                         busy_o,
    output logic                         done_o,

    output logic                         dir_rd_o,
    output logic [SetWidth-1:0]          dir_rd_set_o,
    input  logic                         dir_rd_gnt_i,
    input  logic [Ways-1:0]              dir_valid_i,
    input  logic [Ways-1:0]              dir_dirty_i,
    input  logic [Ways*TagWidth-1:0]     dir_tag_i,

    output logic                         dir_clr_o,
    output logic [SetWidth-1:0]          dir_clr_set_o,
    output logic [Ways-1:0]              dir_clr_way_o,

    output logic                         flush_alloc_o,
    input  logic                         flush_alloc_ready_i,
    output logic [TagWidth+SetWidth-1:0] flush_alloc_nline_o,
    output logic [Ways-1:0]              flush_alloc_way_o,
    input  logic                         flush_empty_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLatch,
        StScan,
        StDrain,
        StDone
    } state_e;

    localparam logic [SetWidth-1:0] LastSet = SetWidth'(Sets - 1);

    state_e                     state_q, state_d;
    logic [SetWidth-1:0]        set_q, set_d;
    logic [Ways-1:0]            mask_q, mask_d;
    logic [Ways*TagWidth-1:0]   tags_q, tags_d;

    logic [Ways-1:0]            sel_oh;
    logic [TagWidth-1:0]        sel_tag;

    // Lowest pending way wins; its tag is picked with an AND-OR mux over the one-hot.
    always_comb begin
        sel_oh  = mask_q & (~mask_q + Ways'(1));
        sel_tag = '0;
        for (int w = 0; w < int'(Ways); w++) begin
            if (sel_oh[w]) begin
                sel_tag = sel_tag | tags_q[w*TagWidth +: TagWidth];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            set_q   <= '0;
            mask_q  <= '0;
            tags_q  <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            mask_q  <= mask_d;
            tags_q  <= tags_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        set_d               = set_q;
        mask_d              = mask_q;
        tags_d              = tags_q;
        start_ready_o       = 1'b0;
        done_o              = 1'b0;
        dir_rd_o            = 1'b0;
        dir_rd_set_o        = '0;
        dir_clr_o           = 1'b0;
        dir_clr_set_o       = '0;
        dir_clr_way_o       = '0;
        flush_alloc_o       = 1'b0;
        flush_alloc_nline_o = '0;
        flush_alloc_way_o   = '0;

        case (state_q)
            StIdle: begin
                start_ready_o = 1'b1;
                if (start_i) begin
                    set_d   = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                dir_rd_o     = 1'b1;
                dir_rd_set_o = set_q;
                if (dir_rd_gnt_i) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                mask_d  = dir_valid_i & dir_dirty_i;
                tags_d  = dir_tag_i;
                state_d = StScan;
            end
            StScan: begin
                if (mask_q == '0) begin
                    if (set_q == LastSet) begin
                        state_d = StDrain;
                    end else begin
                        set_d   = set_q + SetWidth'(1);
                        state_d = StRead;
                    end
                end else begin
                    flush_alloc_o       = 1'b1;
                    flush_alloc_nline_o = {sel_tag, set_q};
                    flush_alloc_way_o   = sel_oh;
                    // Clear rides on the accept edge, so the dirty bit drops with the handoff.
                    if (flush_alloc_ready_i) begin
                        dir_clr_o     = 1'b1;
                        dir_clr_set_o = set_q;
                        dir_clr_way_o = sel_oh;
                        mask_d        = mask_q & ~sel_oh;
                    end
                end
            end
            StDrain: begin
                if (flush_empty_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_hpdcache_flush_walker.sv
// Directed bench for hpdcache_flush_walker: scenario table plus a mid-walk reset sequence.
module tb_hpdcache_flush_walker;

    localparam int unsigned Sets     = 4;
    localparam int unsigned Ways     = 8;
    localparam int unsigned TagWidth = 20;
    localparam int unsigned SetWidth = 2;

    logic                         clk;
    logic                         rst_i;
    logic                         start_i;
    logic                         start_ready_o;
    logic                         busy_o;
    logic                         done_o;
    logic                         dir_rd_o;
    logic [SetWidth-1:0]          dir_rd_set_o;
    logic                         dir_rd_gnt_i;
    logic [Ways-1:0]              dir_valid_i;
    logic [Ways-1:0]              dir_dirty_i;
    logic [Ways*TagWidth-1:0]     dir_tag_i;
    logic                         dir_clr_o;
    logic [SetWidth-1:0]          dir_clr_set_o;
    logic [Ways-1:0]              dir_clr_way_o;
    logic                         flush_alloc_o;
    logic                         flush_alloc_ready_i;
    logic [TagWidth+SetWidth-1:0] flush_alloc_nline_o;
    logic [Ways-1:0]              flush_alloc_way_o;
    logic                         flush_empty_i;

    hpdcache_flush_walker #(
        .Sets     (Sets),
        .Ways     (Ways),
        .TagWidth (TagWidth)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .start_i             (start_i),
        .start_ready_o       (start_ready_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .dir_rd_o            (dir_rd_o),
        .dir_rd_set_o        (dir_rd_set_o),
        .dir_rd_gnt_i        (dir_rd_gnt_i),
        .dir_valid_i         (dir_valid_i),
        .dir_dirty_i         (dir_dirty_i),
        .dir_tag_i           (dir_tag_i),
        .dir_clr_o           (dir_clr_o),
        .dir_clr_set_o       (dir_clr_set_o),
        .dir_clr_way_o       (dir_clr_way_o),
        .flush_alloc_o       (flush_alloc_o),
        .flush_alloc_ready_i (flush_alloc_ready_i),
        .flush_alloc_nline_o (flush_alloc_nline_o),
        .flush_alloc_way_o   (flush_alloc_way_o),
        .flush_empty_i       (flush_empty_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned dset;
        logic [7:0]  valid;
        logic [7:0]  dirty;
        logic [19:0] tag_base;
        bit          alt_ready;
        int unsigned stall_set;
        int unsigned stall_n;
        int unsigned empty_at;
        int unsigned start_again;
        int unsigned exp_done;
        int unsigned exp_allocs;
        logic [21:0] exp_first_nline;
        logic [7:0]  exp_first_way;
        logic [7:0]  exp_last_way;
        int unsigned exp_rd_set1;
    } vec_t;

    vec_t        vecs[7];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  m_valid[Sets];
    logic [7:0]  m_dirty[Sets];
    logic [19:0] m_tag[Sets][Ways];
    int          rs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_dir(input int s);
        dir_valid_i = m_valid[s];
        dir_dirty_i = m_dirty[s];
        for (int w = 0; w < int'(Ways); w++) dir_tag_i[w*TagWidth +: TagWidth] = m_tag[s][w];
    endtask

    task automatic load(input vec_t v);
        for (int s = 0; s < int'(Sets); s++) begin
            m_valid[s] = 8'hFF;
            m_dirty[s] = 8'h00;
            for (int w = 0; w < int'(Ways); w++) m_tag[s][w] = 20'(32'hABC00 + s * 16 + w);
        end
        m_valid[v.dset] = v.valid;
        m_dirty[v.dset] = v.dirty;
        for (int w = 0; w < int'(Ways); w++) m_tag[v.dset][w] = v.tag_base + 20'(w);
        rs = 0;
    endtask

    task automatic run_case(input vec_t v, input string nm);
        int          done_cyc = 0;
        int          done_cnt = 0;
        int          allocs = 0;
        int          busy_cnt = 0;
        int          rd1 = 0;
        int          stall_left = int'(v.stall_n);
        bit          ph = 1'b0;
        bit          prev_stall = 1'b0;
        bit          finished = 1'b0;
        logic [21:0] prev_nline = '0;
        logic [7:0]  prev_way = '0;
        logic [21:0] first_nline = '0;
        logic [7:0]  first_way = '0;
        logic [7:0]  last_way = '0;
        logic [7:0]  pend;
        int          idx;
        int          s;
        load(v);
        drive_dir(0);
        @(negedge clk);
        start_i             = 1'b1;
        flush_alloc_ready_i = 1'b1;
        flush_empty_i       = 1'b1;
        dir_rd_gnt_i        = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
            start_i             = (v.start_again != 0 && cyc == int'(v.start_again));
            flush_empty_i       = (cyc >= int'(v.empty_at));
            flush_alloc_ready_i = v.alt_ready ? ph : 1'b1;
            drive_dir(rs);
            #1;
            dir_rd_gnt_i = 1'b1;
            if (dir_rd_o && int'(dir_rd_set_o) == int'(v.stall_set) && stall_left > 0) begin
                dir_rd_gnt_i = 1'b0;
                stall_left--;
            end
            #1;
            if (cyc == 1) begin
                chk({nm, "_first_rd"}, dir_rd_o, 1);
                chk({nm, "_first_set"}, dir_rd_set_o, 0);
            end
            if (dir_rd_o && dir_rd_set_o == 2'd1) rd1++;
            if (busy_o) busy_cnt++;
            chk({nm, "_clr_eq_accept"}, dir_clr_o, flush_alloc_o & flush_alloc_ready_i);
            if (!dir_rd_o) chk({nm, "_rd_set_zero"}, dir_rd_set_o, 0);
            if (!flush_alloc_o) chk({nm, "_alloc_zero"}, {flush_alloc_nline_o, flush_alloc_way_o}, 0);
            if (!dir_clr_o) chk({nm, "_clr_zero"}, {dir_clr_set_o, dir_clr_way_o}, 0);
            if (prev_stall)
                chk({nm, "_stall_stable"}, {flush_alloc_o, flush_alloc_nline_o, flush_alloc_way_o},
                    {1'b1, prev_nline, prev_way});
            if (flush_alloc_o && flush_alloc_ready_i) begin
                s    = int'(flush_alloc_nline_o[1:0]);
                pend = m_valid[s] & m_dirty[s];
                idx  = 0;
                for (int w = 7; w >= 0; w--) if (pend[w]) idx = w;
                chk({nm, "_alloc_way"}, flush_alloc_way_o, (pend == 0) ? 8'h00 : 8'(1 << idx));
                chk({nm, "_alloc_tag"}, flush_alloc_nline_o[21:2], m_tag[s][idx]);
                chk({nm, "_clr_set"}, dir_clr_set_o, flush_alloc_nline_o[1:0]);
                chk({nm, "_clr_way"}, dir_clr_way_o, flush_alloc_way_o);
                if (allocs == 0) begin
                    first_nline = flush_alloc_nline_o;
                    first_way   = flush_alloc_way_o;
                end
                last_way = flush_alloc_way_o;
                allocs++;
                m_dirty[s] = m_dirty[s] & ~dir_clr_way_o;
            end
            prev_stall = flush_alloc_o && !flush_alloc_ready_i;
            prev_nline = flush_alloc_nline_o;
            prev_way   = flush_alloc_way_o;
            if (dir_rd_o && dir_rd_gnt_i) rs = int'(dir_rd_set_o);
            if (done_o) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc != 0 && cyc == done_cyc + 1) begin
                chk({nm, "_idle_ready"}, {start_ready_o, busy_o}, 2'b10);
                finished = 1'b1;
            end
            if (v.alt_ready) ph = flush_alloc_o ? ~ph : 1'b0;
            if (!finished) @(negedge clk);
        end
        start_i = 1'b0;
        chk({nm, "_terminated"}, finished, 1);
        chk({nm, "_done_cycle"}, done_cyc, v.exp_done);
        chk({nm, "_done_pulses"}, done_cnt, 1);
        chk({nm, "_busy_cycles"}, busy_cnt, v.exp_done);
        chk({nm, "_alloc_count"}, allocs, v.exp_allocs);
        chk({nm, "_rd_set1_cycles"}, rd1, v.exp_rd_set1);
        if (v.exp_allocs != 0) begin
            chk({nm, "_first_nline"}, first_nline, v.exp_first_nline);
            chk({nm, "_first_way"}, first_way, v.exp_first_way);
            chk({nm, "_last_way"}, last_way, v.exp_last_way);
        end
    endtask

    initial begin
        bit seen;
        vecs[0] = '{dset:0, valid:8'hFF, dirty:8'h00, tag_base:20'h0, alt_ready:0, stall_set:0,
                    stall_n:0, empty_at:0, start_again:0, exp_done:14, exp_allocs:0,
                    exp_first_nline:22'h0, exp_first_way:8'h0, exp_last_way:8'h0, exp_rd_set1:1};
        vecs[1] = '{dset:2, valid:8'hFF, dirty:8'h20, tag_base:20'h12340, alt_ready:0, stall_set:0,
                    stall_n:0, empty_at:0, start_again:0, exp_done:15, exp_allocs:1,
                    exp_first_nline:22'h48D16, exp_first_way:8'h20, exp_last_way:8'h20,
                    exp_rd_set1:1};
        vecs[2] = '{dset:0, valid:8'hFF, dirty:8'hFF, tag_base:20'h00100, alt_ready:1, stall_set:0,
                    stall_n:0, empty_at:0, start_again:0, exp_done:30, exp_allocs:8,
                    exp_first_nline:22'h00400, exp_first_way:8'h01, exp_last_way:8'h80,
                    exp_rd_set1:1};
        vecs[3] = '{dset:1, valid:8'hF7, dirty:8'h08, tag_base:20'h0, alt_ready:0, stall_set:1,
                    stall_n:5, empty_at:0, start_again:0, exp_done:19, exp_allocs:0,
                    exp_first_nline:22'h0, exp_first_way:8'h0, exp_last_way:8'h0, exp_rd_set1:6};
        vecs[4] = '{dset:0, valid:8'hFF, dirty:8'h00, tag_base:20'h0, alt_ready:0, stall_set:0,
                    stall_n:0, empty_at:23, start_again:0, exp_done:24, exp_allocs:0,
                    exp_first_nline:22'h0, exp_first_way:8'h0, exp_last_way:8'h0, exp_rd_set1:1};
        vecs[5] = '{dset:0, valid:8'hFF, dirty:8'h00, tag_base:20'h0, alt_ready:0, stall_set:0,
                    stall_n:0, empty_at:0, start_again:5, exp_done:14, exp_allocs:0,
                    exp_first_nline:22'h0, exp_first_way:8'h0, exp_last_way:8'h0, exp_rd_set1:1};
        vecs[6] = '{dset:3, valid:8'hFF, dirty:8'h42, tag_base:20'hFFFF0, alt_ready:0, stall_set:0,
                    stall_n:0, empty_at:0, start_again:0, exp_done:16, exp_allocs:2,
                    exp_first_nline:22'h3FFFC7, exp_first_way:8'h02, exp_last_way:8'h40,
                    exp_rd_set1:1};

        rst_i               = 1'b1;
        start_i             = 1'b0;
        dir_rd_gnt_i        = 1'b1;
        flush_alloc_ready_i = 1'b1;
        flush_empty_i       = 1'b1;
        load(vecs[0]);
        drive_dir(0);
        #1;
        chk("reset_outputs", {start_ready_o, busy_o, done_o, dir_rd_o, dir_clr_o, flush_alloc_o},
            6'b100000);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;

        foreach (vecs[i]) run_case(vecs[i], $sformatf("vec%0d", i));

        // Reset while an allocation is held off by backpressure
        load(vecs[0]);
        m_dirty[0] = 8'hFF;
        @(negedge clk);
        start_i             = 1'b1;
        flush_alloc_ready_i = 1'b0;
        dir_rd_gnt_i        = 1'b1;
        drive_dir(0);
        @(negedge clk);
        start_i = 1'b0;
        seen    = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            drive_dir(rs);
            #1;
            if (dir_rd_o) rs = int'(dir_rd_set_o);
            if (flush_alloc_o) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rst_alloc_stalled", seen, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_async_outputs",
            {start_ready_o, busy_o, done_o, dir_rd_o, dir_clr_o, flush_alloc_o}, 6'b100000);
        chk("rst_async_alloc_zero", {flush_alloc_nline_o, flush_alloc_way_o}, 0);
        @(negedge clk);
        rst_i               = 1'b0;
        flush_alloc_ready_i = 1'b1;
        run_case(vecs[1], "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
